// File: rtl/key_device_pkg.sv
// -----------------------------------------------------------------------------
// key_device_pkg
//   Shared definitions for the memory-mapped KEY peripheral:
//     - KEY_BITS     : number of push buttons (width of the key vector)
//     - ADDR_KDATA   : key data register address
//     - ADDR_KCTRL   : key control/status register address
//     - READY_BIT / OVERRUN_BIT / IE_BIT : KCTRL bit positions
//     - key_vec_t    : KEY_BITS-wide key vector, bit = 1 means pressed
//     - kctrl_word() : packs the status flags into a 32-bit KCTRL read word
//   Build option: KEYDEV_DEBOUNCE_EN (see key_debouncer.sv).
// -----------------------------------------------------------------------------
package key_device_pkg;

  localparam int KEY_BITS = 4;

  localparam logic [31:0] ADDR_KDATA = 32'hF000_0010;
  localparam logic [31:0] ADDR_KCTRL = 32'hF000_0110;

  localparam int READY_BIT   = 0;
  localparam int OVERRUN_BIT = 2;
  localparam int IE_BIT      = 8;

  typedef logic [KEY_BITS-1:0] key_vec_t;

  // Every bit other than the three flags reads back as zero.
  function automatic logic [31:0] kctrl_word(input logic ready,
                                             input logic overrun,
                                             input logic ie);
    logic [31:0] w;
    w              = '0;
    w[READY_BIT]   = ready;
    w[OVERRUN_BIT] = overrun;
    w[IE_BIT]      = ie;
    return w;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
//   Synchronises the raw active-low KEY pins into the clk domain, inverts them
//   (internal 1 = pressed) and commits a new key state into kdata.
//
//   Build option KEYDEV_DEBOUNCE_EN:
//     defined   - the whole key vector must stay unchanged for DEBOUNCE_CYCLES
//                 consecutive samples before it is committed. Edge-to-commit
//                 latency is 2 (synchroniser) + DEBOUNCE_CYCLES + 1 cycles.
//     undefined - no filtering; kdata follows the synchronised keys with a
//                 3-cycle edge-to-commit latency. DEBOUNCE_CYCLES is unused.
//
// Ports:
//   clk     in   system clock
//   reset   in   asynchronous reset, active-low
//   key_in  in   raw KEY pins, active-low
//   kdata   out  committed key state, 1 = pressed
//   change  out  high for the single cycle whose clock edge commits a new kdata
// -----------------------------------------------------------------------------
module key_debouncer
  import key_device_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic     clk,
  input  logic     reset,
  input  key_vec_t key_in,
  output key_vec_t kdata,
  output logic     change
);

  // Two-flop synchroniser. Resets to all ones so that released buttons do not
  // look like a press right after reset.
  key_vec_t sync_1;
  key_vec_t sync_2;
  key_vec_t synced;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_1 <= '1;
      sync_2 <= '1;
    end else begin
      sync_1 <= key_in;
      sync_2 <= sync_1;
    end
  end

  assign synced = ~sync_2;

`ifdef KEYDEV_DEBOUNCE_EN

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // candidate holds the vector currently being timed; counter counts how many
  // further samples matched it and saturates at CNT_LAST, so a long-held
  // state never re-triggers.
  key_vec_t         candidate;
  logic [CNT_W-1:0] counter;
  logic             stable;
  logic             window_done;

  assign stable      = (synced == candidate);
  assign window_done = (counter == CNT_LAST);

  // Combinational so the status logic sees the event on the same edge that
  // loads kdata.
  assign change = stable && window_done && (candidate != kdata);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      candidate <= '0;
      counter   <= '0;
      kdata     <= '0;
    end else if (!stable) begin
      candidate <= synced;
      counter   <= '0;
    end else if (!window_done) begin
      counter <= counter + 1'b1;
    end else if (candidate != kdata) begin
      kdata <= candidate;
    end
  end

`else

  // Window length is meaningless without the filter.
  localparam int unused_window = DEBOUNCE_CYCLES;

  assign change = (synced != kdata);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      kdata <= '0;
    end else begin
      kdata <= synced;
    end
  end

`endif

endmodule

// File: rtl/key_device.sv
// -----------------------------------------------------------------------------
// key_device
//   Memory-mapped KEY peripheral on the stage-2 data bus. Debounced key state
//   is readable at KDATA; committed changes set a ready flag (and overrun if
//   the previous change was never read) in KCTRL. irq = ready & ie, registered.
//
//   Build option KEYDEV_DEBOUNCE_EN enables the debounce window inside
//   key_debouncer; without it key changes are committed unfiltered.
//
// Ports:
//   clk       in   system clock
//   reset     in   asynchronous reset, active-low
//   abus      in   bus address (buffered ALU output)
//   dbus_in   in   bus write data
//   wren      in   bus write strobe
//   rden      in   bus read strobe (buffered memtoReg)
//   key_in    in   raw KEY pins, active-low
//   dbus_out  out  read data, zero whenever this block is not being read
//   irq       out  interrupt request
//
// Bus semantics: a transfer happens in every cycle where a strobe is high and
// abus decodes to one of our registers; there is no stall. wren has priority:
// with both strobes high the cycle is a write, dbus_out stays zero and no read
// side effect occurs. Read data is combinational in the addressing cycle; the
// KDATA read side effect (ready clear) and all writes take effect on the
// closing clock edge.
//
// KCTRL layout: bit0 ready (read-only), bit2 overrun (write 0 to clear,
// write 1 ignored), bit8 ie (read/write).
// -----------------------------------------------------------------------------
module key_device
  import key_device_pkg::*;
#(
  parameter int DBITS           = 32,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] abus,
  input  logic [DBITS-1:0] dbus_in,
  input  logic             wren,
  input  logic             rden,
  input  key_vec_t         key_in,
  output logic [DBITS-1:0] dbus_out,
  output logic             irq
);

  localparam logic [DBITS-1:0] KDATA_ADDR = DBITS'(ADDR_KDATA);
  localparam logic [DBITS-1:0] KCTRL_ADDR = DBITS'(ADDR_KCTRL);

  key_vec_t kdata;
  logic     change;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk    (clk),
    .reset  (reset),
    .key_in (key_in),
    .kdata  (kdata),
    .change (change)
  );

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic sel_kdata;
  logic sel_kctrl;
  logic bus_read;
  logic kdata_read;
  logic kctrl_write;

  assign sel_kdata   = (abus == KDATA_ADDR);
  assign sel_kctrl   = (abus == KCTRL_ADDR);
  assign bus_read    = rden && !wren;
  assign kdata_read  = bus_read && sel_kdata;
  assign kctrl_write = wren && sel_kctrl;

  // Only bits 2 and 8 of the write data are meaningful.
  logic unused_wdata;
  assign unused_wdata = ^{dbus_in[DBITS-1:IE_BIT+1],
                          dbus_in[IE_BIT-1:OVERRUN_BIT+1],
                          dbus_in[OVERRUN_BIT-1:0]};

  // ---------------------------------------------------------------------------
  // Status registers
  // ---------------------------------------------------------------------------
  logic ready_q;
  logic overrun_q;
  logic ie_q;
  logic irq_q;

  // A change arriving on the same edge as a KDATA read re-arms ready; the
  // read consumed the old value, so this is not an overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q <= 1'b0;
    end else if (change) begin
      ready_q <= 1'b1;
    end else if (kdata_read) begin
      ready_q <= 1'b0;
    end
  end

  // Set beats a simultaneous write-0 clear so that a lost event is never hidden.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overrun_q <= 1'b0;
    end else if (change && ready_q && !kdata_read) begin
      overrun_q <= 1'b1;
    end else if (kctrl_write && !dbus_in[OVERRUN_BIT]) begin
      overrun_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ie_q <= 1'b0;
    end else if (kctrl_write) begin
      ie_q <= dbus_in[IE_BIT];
    end
  end

  // Registered so irq is a clean flop output for the interrupt controller.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= ready_q && ie_q;
    end
  end

  assign irq = irq_q;

  // ---------------------------------------------------------------------------
  // Read mux: this slice is OR-combined with other devices, so it must drive
  // zero whenever it is not the addressed reader.
  // ---------------------------------------------------------------------------
  always_comb begin
    dbus_out = '0;
    if (bus_read && sel_kdata) begin
      dbus_out = DBITS'(kdata);
    end else if (bus_read && sel_kctrl) begin
      dbus_out = DBITS'(kctrl_word(ready_q, overrun_q, ie_q));
    end
  end

endmodule

// File: tb/tb_key_device.sv
// -----------------------------------------------------------------------------
// tb_key_device
//   Directed bench for key_device with DEBOUNCE_CYCLES = 4. Edge-to-commit
//   latency LAT is 7 with KEYDEV_DEBOUNCE_EN defined and 3 without it.
//   Inputs are driven on the falling edge; outputs are sampled 1 time unit
//   after it, away from the rising (active) edge.
// -----------------------------------------------------------------------------
module tb_key_device;
  import key_device_pkg::*;

  localparam int DBITS = 32;
  localparam int DB    = 4;
`ifdef KEYDEV_DEBOUNCE_EN
  localparam int LAT = 2 + DB + 1;
`else
  localparam int LAT = 3;
`endif

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [DBITS-1:0] abus = '0;
  logic [DBITS-1:0] dbus_in = '0;
  logic             wren = 1'b0;
  logic             rden = 1'b0;
  logic [3:0]       key_in = 4'hF;
  logic [DBITS-1:0] dbus_out;
  logic             irq;

  always #5 clk = ~clk;

  key_device #(
    .DBITS          (DBITS),
    .DEBOUNCE_CYCLES(DB)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .abus     (abus),
    .dbus_in  (dbus_in),
    .wren     (wren),
    .rden     (rden),
    .key_in   (key_in),
    .dbus_out (dbus_out),
    .irq      (irq)
  );

  int total = 0;
  int bad   = 0;
  logic [DBITS-1:0] exp_q[$];
  logic [DBITS-1:0] d;
  logic [DBITS-1:0] e;

  // ---------------------------------------------------------------------------
  // Driver tasks (all start and end just after a falling edge)
  // ---------------------------------------------------------------------------
  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Combinational read with no clock edge, hence no side effect.
  task automatic peek(input logic [DBITS-1:0] addr, output logic [DBITS-1:0] v);
    abus = addr;
    rden = 1'b1;
    wren = 1'b0;
    #1;
    v    = dbus_out;
    rden = 1'b0;
    abus = '0;
  endtask

  // Full KDATA read cycle: value sampled before the edge, ready cleared at it.
  task automatic kd_read(output logic [DBITS-1:0] v);
    abus = ADDR_KDATA;
    rden = 1'b1;
    wren = 1'b0;
    #1;
    v = dbus_out;
    @(posedge clk);
    @(negedge clk);
    rden = 1'b0;
    abus = '0;
  endtask

  task automatic bus_write(input logic [DBITS-1:0] addr, input logic [DBITS-1:0] data);
    abus    = addr;
    dbus_in = data;
    wren    = 1'b1;
    rden    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    wren    = 1'b0;
    dbus_in = '0;
    abus    = '0;
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    @(negedge clk);
    peek(ADDR_KCTRL, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_kctrl: got %h want %h", d, 32'h0); end
    peek(ADDR_KDATA, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_kdata: got %h want %h", d, 32'h0); end
    peek(32'h0000_1234, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_other_addr: got %h want %h", d, 32'h0); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL rst_irq: got %b want %b", irq, 1'b0); end
    @(negedge clk);
    reset = 1'b1;
    cycle(2);
    peek(ADDR_KCTRL, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL post_rst_kctrl: got %h want %h", d, 32'h0); end
  endtask

  task automatic test_bus_decode();
    // Unaddressed (no rden) on a valid address reads zero.
    abus = ADDR_KCTRL;
    #1;
    total++; if (dbus_out !== 32'h0) begin bad++; $display("FAIL no_rden: got %h want %h", dbus_out, 32'h0); end
    // rden and wren together: write only, no read data.
    dbus_in = 32'h0000_0100;
    rden    = 1'b1;
    wren    = 1'b1;
    #1;
    total++; if (dbus_out !== 32'h0) begin bad++; $display("FAIL rd_wr_same: got %h want %h", dbus_out, 32'h0); end
    @(posedge clk);
    @(negedge clk);
    rden = 1'b0; wren = 1'b0; dbus_in = '0; abus = '0;
    peek(ADDR_KCTRL, d);
    total++; if (d !== 32'h100) begin bad++; $display("FAIL ie_set_by_rw: got %h want %h", d, 32'h100); end
    bus_write(ADDR_KCTRL, 32'h0);
    peek(ADDR_KCTRL, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL ie_cleared: got %h want %h", d, 32'h0); end
  endtask

  task automatic test_press();
    key_in = 4'b1110;
    cycle(LAT - 1);
    peek(ADDR_KCTRL, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL press_early: got %h want %h", d, 32'h0); end
    cycle(1);
    peek(ADDR_KCTRL, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL press_kctrl: got %h want %h", d, 32'h1); end
    peek(ADDR_KDATA, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL press_kdata: got %h want %h", d, 32'h1); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL press_irq_masked: got %b want %b", irq, 1'b0); end
    kd_read(d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL press_read: got %h want %h", d, 32'h1); end
    peek(ADDR_KCTRL, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL press_ready_clr: got %h want %h", d, 32'h0); end
    bus_write(ADDR_KDATA, 32'hF);
    peek(ADDR_KDATA, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL kdata_write_ignored: got %h want %h", d, 32'h1); end
  endtask

  task automatic test_glitch();
    key_in = 4'b1100;
    cycle(2);
    key_in = 4'b1110;
    cycle(LAT + 6);
    peek(ADDR_KDATA, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL glitch_kdata: got %h want %h", d, 32'h1); end
    peek(ADDR_KCTRL, d);
`ifdef KEYDEV_DEBOUNCE_EN
    e = 32'h0;  // filtered out entirely
`else
    e = 32'h5;  // two unfiltered changes, second one overruns
`endif
    total++; if (d !== e) begin bad++; $display("FAIL glitch_kctrl: got %h want %h", d, e); end
    bus_write(ADDR_KCTRL, 32'h0);
    kd_read(d);
    peek(ADDR_KCTRL, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL glitch_cleanup: got %h want %h", d, 32'h0); end
  endtask

  task automatic test_overrun();
    key_in = 4'b1100;
    exp_q.push_back(32'h3);
    cycle(LAT + 1);
    peek(ADDR_KDATA, d);
    e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL ovr_kdata1: got %h want %h", d, e); end
    peek(ADDR_KCTRL, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL ovr_kctrl1: got %h want %h", d, 32'h1); end
    key_in = 4'b1110;
    exp_q.push_back(32'h1);
    cycle(LAT + 1);
    peek(ADDR_KCTRL, d);
    total++; if (d !== 32'h5) begin bad++; $display("FAIL ovr_kctrl2: got %h want %h", d, 32'h5); end
    peek(ADDR_KDATA, d);
    e = exp_q.pop_front();
    total++; if (d !== e) begin bad++; $display("FAIL ovr_kdata2: got %h want %h", d, e); end
    bus_write(ADDR_KCTRL, 32'h4);  // writing 1 to overrun has no effect
    peek(ADDR_KCTRL, d);
    total++; if (d !== 32'h5) begin bad++; $display("FAIL ovr_write1: got %h want %h", d, 32'h5); end
    bus_write(ADDR_KCTRL, 32'h0);
    peek(ADDR_KCTRL, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL ovr_clear: got %h want %h", d, 32'h1); end
    kd_read(d);
    peek(ADDR_KCTRL, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL ovr_read_clr: got %h want %h", d, 32'h0); end
  endtask

  task automatic test_irq();
    bus_write(ADDR_KCTRL, 32'h100);
    peek(ADDR_KCTRL, d);
    total++; if (d !== 32'h100) begin bad++; $display("FAIL irq_ie: got %h want %h", d, 32'h100); end
    key_in = 4'b0110;
    cycle(LAT);
    peek(ADDR_KCTRL, d);
    total++; if (d !== 32'h101) begin bad++; $display("FAIL irq_ready: got %h want %h", d, 32'h101); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_not_yet: got %b want %b", irq, 1'b0); end
    cycle(1);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise: got %b want %b", irq, 1'b1); end
    kd_read(d);
    total++; if (d !== 32'h9) begin bad++; $display("FAIL irq_kdata: got %h want %h", d, 32'h9); end
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_hold: got %b want %b", irq, 1'b1); end
    cycle(1);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_fall: got %b want %b", irq, 1'b0); end
  endtask

  task automatic test_back_to_back();
    // ie stays 1 from test_irq.
    key_in = 4'b0111;
    cycle(LAT);
    peek(ADDR_KCTRL, d);
    total++; if (d !== 32'h101) begin bad++; $display("FAIL b2b_first: got %h want %h", d, 32'h101); end
    // KDATA read lands on the next commit edge.
    key_in = 4'b1111;
    cycle(LAT - 1);
    kd_read(d);
    total++; if (d !== 32'h8) begin bad++; $display("FAIL b2b_read_old: got %h want %h", d, 32'h8); end
    peek(ADDR_KCTRL, d);
    total++; if (d !== 32'h101) begin bad++; $display("FAIL b2b_read_evt: got %h want %h", d, 32'h101); end
    peek(ADDR_KDATA, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL b2b_kdata: got %h want %h", d, 32'h0); end
    // Overrun-clear write lands on the next commit edge while ready=1.
    key_in = 4'b1110;
    cycle(LAT - 1);
    bus_write(ADDR_KCTRL, 32'h100);
    peek(ADDR_KCTRL, d);
    total++; if (d !== 32'h105) begin bad++; $display("FAIL b2b_set_wins: got %h want %h", d, 32'h105); end
    bus_write(ADDR_KCTRL, 32'h0);
    kd_read(d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL b2b_final_kdata: got %h want %h", d, 32'h1); end
    peek(ADDR_KCTRL, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL b2b_cleanup: got %h want %h", d, 32'h0); end
  endtask

  task automatic test_reset_mid();
    key_in = 4'b1101;
    cycle(LAT - 2);
    reset = 1'b0;
    #1;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL mid_rst_irq: got %b want %b", irq, 1'b0); end
    peek(ADDR_KDATA, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_rst_kdata: got %h want %h", d, 32'h0); end
    @(negedge clk);
    reset = 1'b1;
    cycle(LAT - 1);
    peek(ADDR_KCTRL, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mid_rst_early: got %h want %h", d, 32'h0); end
    cycle(1);
    peek(ADDR_KCTRL, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL mid_rst_event: got %h want %h", d, 32'h1); end
    peek(ADDR_KDATA, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL mid_rst_kdata2: got %h want %h", d, 32'h2); end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and final report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_bus_decode();
    test_press();
    test_glitch();
    test_overrun();
    test_irq();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

endmodule
